// File: rtl/idvr_bitlogic_serial.sv
// Bit-serial (slice-serial) bitwise logic unit.
// Accepts one command (I0, I1, S) in IDLE, evaluates it C bits per clock,
// LSB slice first, then presents the full W-bit result with a zero flag
// until the consumer takes it.
// Ports:
//   CLK, RSTN      clock, asynchronous active-low reset
//   IVLD / IRDY    command handshake (IRDY high only in IDLE)
//   I0, I1, S      operands and op code (00 XOR, 01 NOT I0, 10 OR, 11 AND)
//   OVLD / ORDY    result handshake
//   O, OZ          result and result-is-zero flag
module idvr_bitlogic_serial #(
   parameter int unsigned W = 32,
   parameter int unsigned C = 8
) (
   input  logic         CLK,
   input  logic         RSTN,
   input  logic         IVLD,
   output logic         IRDY,
   input  logic [W-1:0] I0,
   input  logic [W-1:0] I1,
   input  logic [1:0]   S,
   output logic         OVLD,
   input  logic         ORDY,
   output logic [W-1:0] O,
   output logic         OZ
);

   localparam int unsigned N  = W / C;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  a_q, b_q;
   logic [1:0]    op_q;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  o_q, o_d;
   logic          oz_q, oz_d;
   logic          irdy_q, ovld_q;
   logic          load_c;
   logic          last_c;
   int unsigned   idx_c;
   logic [C-1:0]  sa_c, sb_c, slice_c;

   // Current slice of the latched operands and its result.
   always_comb begin
      idx_c = 32'(cnt_q) * C;
      sa_c  = a_q[idx_c +: C];
      sb_c  = b_q[idx_c +: C];
      unique case (op_q)
         2'b00:   slice_c = sa_c ^ sb_c;
         2'b01:   slice_c = ~sa_c;
         2'b10:   slice_c = sa_c | sb_c;
         default: slice_c = sa_c & sb_c;
      endcase
   end

   assign last_c = (cnt_q == CW'(N - 1));

   // State register.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, slice counter, partial and final result.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      o_d     = o_q;
      oz_d    = oz_q;
      load_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (IVLD) begin
               load_c  = 1'b1;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d[idx_c +: C] = slice_c;
            if (last_c) begin
               // Result becomes visible on O only once all slices are in.
               o_d     = acc_d;
               oz_d    = (acc_d == '0);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (ORDY) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered handshake outputs.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         acc_q  <= '0;
         o_q    <= '0;
         oz_q   <= 1'b0;
         irdy_q <= 1'b1;
         ovld_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         o_q    <= o_d;
         oz_q   <= oz_d;
         irdy_q <= (state_d == IDLE);
         ovld_q <= (state_d == DONE);
         if (load_c) begin
            a_q  <= I0;
            b_q  <= I1;
            op_q <= S;
         end
      end
   end

   assign IRDY = irdy_q;
   assign OVLD = ovld_q;
   assign O    = o_q;
   assign OZ   = oz_q;

endmodule

// File: tb/tb_idvr_bitlogic_serial.sv
// Scoreboard bench for idvr_bitlogic_serial (W=32/C=8 plus a W=8/C=8 instance).
module tb_idvr_bitlogic_serial;

   localparam int unsigned W = 32;
   localparam int unsigned C = 8;
   localparam int unsigned N = W / C;

   logic         clk = 1'b0;
   logic         rstn;
   logic         ivld, irdy, ovld, ordy, oz;
   logic [W-1:0] i0, i1, o;
   logic [1:0]   s;

   logic         ivld1, irdy1, ovld1, ordy1, oz1;
   logic [7:0]   i0_1, i1_1, o1;
   logic [1:0]   s1;

   always #5 clk = ~clk;

   idvr_bitlogic_serial #(.W(W), .C(C)) u_dut (
      .CLK(clk), .RSTN(rstn), .IVLD(ivld), .IRDY(irdy), .I0(i0), .I1(i1),
      .S(s), .OVLD(ovld), .ORDY(ordy), .O(o), .OZ(oz)
   );

   idvr_bitlogic_serial #(.W(8), .C(8)) u_n1 (
      .CLK(clk), .RSTN(rstn), .IVLD(ivld1), .IRDY(irdy1), .I0(i0_1), .I1(i1_1),
      .S(s1), .OVLD(ovld1), .ORDY(ordy1), .O(o1), .OZ(oz1)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         zero;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   ordy_mode = 1;   // 0 random, 1 always ready, 2 stalled
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc++;

   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
      case (op)
         2'd0:    return a ^ b;
         2'd1:    return ~a;
         2'd2:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitor: drives ORDY, checks results against the scoreboard.
   logic         ovld_p = 1'b0, hs_p = 1'b0, oz_p = 1'b0;
   logic [W-1:0] o_p = '0;
   always @(negedge clk) begin
      if (!rstn || !mon_en) begin
         ordy   = 1'b0;
         ovld_p = 1'b0;
         hs_p   = 1'b0;
      end else begin
         case (ordy_mode)
            0:       ordy = 1'($urandom_range(0, 1));
            1:       ordy = 1'b1;
            default: ordy = 1'b0;
         endcase
         if (hs_p) begin
            chk("ovld_drop_after_hs", ovld, 0);
            chk("irdy_after_hs", irdy, 1);
         end
         if (ovld) chk("irdy_low_in_done", irdy, 0);
         if (ovld_p && !hs_p) begin
            chk("ovld_held_in_stall", ovld, 1);
            chk("o_stable_in_stall", o, o_p);
            chk("oz_stable_in_stall", oz, oz_p);
         end
         if (ovld && !ovld_p) begin
            if (q.size() == 0) fail_now("spurious_ovld");
            else begin
               chk("latency", 64'(cyc - q[0].acc), N);
               chk("result", o, q[0].res);
               chk("zero_flag", oz, q[0].zero);
            end
         end
         if (ovld && ordy && q.size() > 0) void'(q.pop_front());
         hs_p   = ovld && ordy;
         ovld_p = ovld;
         o_p    = o;
         oz_p   = oz;
      end
   end

   // One negedge of filler: garbage with IVLD high while busy, IVLD low when idle.
   task automatic idle_step();
      @(negedge clk);
      if (irdy) ivld = 1'b0;
      else begin
         ivld = 1'b1;
         i0   = $urandom;
         i1   = $urandom;
         s    = 2'($urandom);
      end
   endtask

   // Hold IVLD high; scramble inputs until IRDY, then present the command.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        output int acc);
      acc = -1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         ivld = 1'b1;
         if (irdy) begin
            i0 = a; i1 = b; s = op;
            acc = cyc + 1;
            q.push_back('{model(a, b, op), model(a, b, op) == '0, cyc + 1});
            return;
         end
         i0 = $urandom;
         i1 = $urandom;
         s  = 2'($urandom);
      end
      fail_now("issue_timeout");
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 300; t++) begin
         idle_step();
         if (q.size() == 0 && !ovld) return;
      end
      fail_now("drain_timeout");
   endtask

   int           acc1, acc2, dummy;
   logic [W-1:0] ra, rb;

   initial begin
      rstn = 1'b0; ivld = 1'b0; i0 = '0; i1 = '0; s = '0; ordy = 1'b0;
      ivld1 = 1'b0; i0_1 = '0; i1_1 = '0; s1 = '0; ordy1 = 1'b0;
      #12;
      chk("rst_irdy", irdy, 1);
      chk("rst_ovld", ovld, 0);
      chk("rst_o", o, 0);
      chk("rst_oz", oz, 0);

      // Release and accept on the very first edge: XOR.
      @(negedge clk);
      chk("irdy_at_release", irdy, 1);
      rstn = 1'b1; mon_en = 1'b1; ordy_mode = 1;
      ivld = 1'b1; i0 = 32'hF0F0_1234; i1 = 32'hFFFF_0000; s = 2'b00;
      q.push_back('{model(i0, i1, s), model(i0, i1, s) == '0, cyc + 1});
      wait_drain();
      chk("xor_hold", o, 32'h0F0F_1234);

      // NOT ignores I1.
      issue(32'hFFFF_FFFF, 32'h1234_5678, 2'b01, dummy);
      wait_drain();
      chk("not_hold", o, 32'h0000_0000);

      // Stall with scrambled inputs during BUSY.
      ordy_mode = 2;
      issue(32'hAAAA_5555, 32'h0F0F_0F0F, 2'b11, dummy);
      for (int t = 0; t < 50 && !ovld; t++) idle_step();
      repeat (10) idle_step();
      ordy_mode = 1;
      wait_drain();
      chk("and_hold", o, 32'h0A0A_0505);

      // Back-to-back with IVLD held high.
      issue(32'h1200_0034, 32'h0056_7800, 2'b10, acc1);
      issue(32'hFF00_FF00, 32'h0FF0_0FF0, 2'b11, acc2);
      chk("b2b_spacing", 64'(acc2 - acc1), N + 2);
      wait_drain();

      // Random commands with random backpressure and gaps.
      ordy_mode = 0;
      repeat (150) begin
         ra = $urandom;
         case ($urandom_range(0, 2))
            0:       rb = $urandom;
            1:       rb = ~ra;
            default: rb = ra;
         endcase
         issue(ra, rb, 2'($urandom), dummy);
         repeat ($urandom_range(0, 2)) idle_step();
      end
      ordy_mode = 1;
      wait_drain();

      // Reset during slice 2.
      issue(32'h0000_0001, 32'h0, 2'b00, dummy);
      wait_drain();
      issue(32'h1357_9BDF, 32'h2468_ACE0, 2'b10, dummy);
      repeat (3) @(posedge clk);
      #3;
      mon_en = 1'b0; rstn = 1'b0; ivld = 1'b0;
      #1;
      chk("midop_rst_ovld", ovld, 0);
      chk("midop_rst_o", o, 0);
      chk("midop_rst_oz", oz, 0);
      chk("midop_rst_irdy", irdy, 1);
      q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1; mon_en = 1'b1;
      chk("irdy_after_midop_rst", irdy, 1);
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         chk("no_stale_ovld", ovld, 0);
      end

      // Single-slice build.
      @(negedge clk);
      chk("n1_irdy", irdy1, 1);
      ivld1 = 1'b1; i0_1 = 8'h3C; i1_1 = 8'hC3; s1 = 2'b10;
      @(negedge clk);
      ivld1 = 1'b0;
      chk("n1_busy_ovld", ovld1, 0);
      @(negedge clk);
      chk("n1_ovld", ovld1, 1);
      chk("n1_o", o1, 8'hFF);
      chk("n1_oz", oz1, 0);
      ordy1 = 1'b1;
      @(negedge clk);
      ordy1 = 1'b0;
      chk("n1_ovld_drop", ovld1, 0);
      chk("n1_irdy_back", irdy1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
